// File: rtl/timer_array_if.sv
// Register/control bus between the SFR block and the timer array.
// The SFR side (master) drives configuration and write strobes and
// observes counters, captures and interrupt flags; the timer array
// is the slave.
interface timer_array_if #(
   parameter int CH    = 4,
   parameter int CNT_W = 16,
   parameter int PRE_W = 8,
   parameter int CH_W  = 2
);
   // configuration and pins
   logic [PRE_W-1:0]    prescale_div;
   logic [CH-1:0]       ext_in;
   logic [CH-1:0]       run;
   logic [2*CH-1:0]     mode;
   logic [CH-1:0]       src_ext;

   // register write port
   logic                wr_en;
   logic [CH_W-1:0]     wr_ch;
   logic                wr_reload;
   logic [CNT_W-1:0]    wr_data;

   // flag acknowledge
   logic [CH-1:0]       flag_clr;

   // status back to the SFR block and interrupt controller
   logic [CH*CNT_W-1:0] cnt_out;
   logic [CH*CNT_W-1:0] cap_out;
   logic [CH-1:0]       ovf;
   logic [CH-1:0]       cap_valid;

   modport master (
      output prescale_div, ext_in, run, mode, src_ext,
      output wr_en, wr_ch, wr_reload, wr_data, flag_clr,
      input  cnt_out, cap_out, ovf, cap_valid
   );

   modport slave (
      input  prescale_div, ext_in, run, mode, src_ext,
      input  wr_en, wr_ch, wr_reload, wr_data, flag_clr,
      output cnt_out, cap_out, ovf, cap_valid
   );
endinterface

// File: rtl/timer_array.sv
// Multi-channel 8051-style timer/counter array.
// CH independent up-counters share one programmable prescaler. Each
// channel runs free-run, auto-reload, one-shot or input-capture mode and
// can count prescaler ticks or falling edges on its external pin.
module timer_array #(
   parameter int CH    = 4,
   parameter int CNT_W = 16,
   parameter int PRE_W = 8,
   parameter int CH_W  = 2
) (
   input  logic         clk,
   input  logic         rst,
   timer_array_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_FREE    = 2'b00,
      MODE_RELOAD  = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_CAPTURE = 2'b11
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // shared prescaler
   logic [PRE_W-1:0]            pre_cnt_q, pre_cnt_d;
   logic                        tick;

   // external pin synchroniser and falling-edge detector
   logic [CH-1:0]               sync1_q, sync2_q, prev_q;
   logic [CH-1:0]               fall_edge;

   // per-channel state; channel i lives in slot [i]
   logic [CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
   logic [CH-1:0][CNT_W-1:0]    reload_q, reload_d;
   logic [CH-1:0][CNT_W-1:0]    cap_q, cap_d;
   logic [CH-1:0]               armed_q, armed_d;
   logic [CH-1:0]               ovf_q, ovf_d;
   logic [CH-1:0]               cap_valid_q, cap_valid_d;

   // per-channel decoded strobes
   mode_e                       ch_mode [CH];
   logic [CH-1:0]               ev;
   logic [CH-1:0]               cap_ev;
   logic [CH-1:0]               wr_cnt_hit;
   logic [CH-1:0]               wr_rel_hit;
   logic [CH-1:0]               ovf_set;

   // Prescaler: one tick every prescale_div+1 cycles, restart from zero on tick.
   always_comb begin
      tick      = (pre_cnt_q == bus.prescale_div);
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
   end

   // Falling edge seen on the synchronised pin (high last cycle, low now).
   assign fall_edge = prev_q & ~sync2_q;

   // Decode per-channel count, capture and write strobes.
   always_comb begin
      // NOTE: every output of a combinational block gets a value before any
      // condition, otherwise synthesis infers a latch to hold the old value.
      ev         = '0;
      cap_ev     = '0;
      wr_cnt_hit = '0;
      wr_rel_hit = '0;
      for (int i = 0; i < CH; i++) begin
         ch_mode[i]    = mode_e'(bus.mode[2*i +: 2]);
         // Capture mode always counts ticks; its pin edge is the capture strobe.
         ev[i]         = bus.run[i] &
                         (((ch_mode[i] == MODE_CAPTURE) || !bus.src_ext[i]) ? tick
                                                                             : fall_edge[i]);
         cap_ev[i]     = bus.run[i] & fall_edge[i] & (ch_mode[i] == MODE_CAPTURE);
         // Matching against each channel index means out-of-range selects hit nothing.
         wr_cnt_hit[i] = bus.wr_en & ~bus.wr_reload & (bus.wr_ch == CH_W'(i));
         wr_rel_hit[i] = bus.wr_en &  bus.wr_reload & (bus.wr_ch == CH_W'(i));
      end
   end

   // Per-channel counter, reload, capture and sticky-flag next state.
   always_comb begin
      cnt_d       = cnt_q;
      reload_d    = reload_q;
      cap_d       = cap_q;
      armed_d     = armed_q;
      ovf_set     = '0;
      ovf_d       = ovf_q;
      cap_valid_d = cap_valid_q;
      for (int i = 0; i < CH; i++) begin
         // A counter write takes priority over a coincident count event.
         if (wr_cnt_hit[i]) begin
            cnt_d[i]   = bus.wr_data;
            armed_d[i] = 1'b1;
         end else if (ev[i]) begin
            case (ch_mode[i])
               MODE_RELOAD: begin
                  if (cnt_q[i] == CNT_MAX) begin
                     cnt_d[i]   = reload_q[i];
                     ovf_set[i] = 1'b1;
                  end else begin
                     cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                  end
               end
               MODE_ONESHOT: begin
                  // Once expired the channel ignores events until rewritten.
                  if (armed_q[i]) begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                     if (cnt_q[i] == CNT_MAX) begin
                        armed_d[i] = 1'b0;
                        ovf_set[i] = 1'b1;
                     end
                  end
               end
               default: begin
                  // Free-run and capture: natural wrap from MAX to zero.
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  if (cnt_q[i] == CNT_MAX) begin
                     ovf_set[i] = 1'b1;
                  end
               end
            endcase
         end

         if (wr_rel_hit[i]) begin
            reload_d[i] = bus.wr_data;
         end

         // Capture the pre-increment value seen during this cycle.
         if (cap_ev[i]) begin
            cap_d[i] = cnt_q[i];
         end

         // A set in the same cycle as a clear wins.
         ovf_d[i]       = (ovf_q[i]       & ~bus.flag_clr[i]) | ovf_set[i];
         cap_valid_d[i] = (cap_valid_q[i] & ~bus.flag_clr[i]) | cap_ev[i];
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples its input from before the edge, independent of statement order.
      if (rst) begin
         pre_cnt_q   <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         // NOTE: these small per-channel arrays are plain flops, not RAM, so
         // every entry is cleared by reset like any other register.
         cnt_q       <= '0;
         reload_q    <= '0;
         cap_q       <= '0;
         armed_q     <= '1;
         ovf_q       <= '0;
         cap_valid_q <= '0;
      end else begin
         pre_cnt_q   <= pre_cnt_d;
         sync1_q     <= bus.ext_in;
         sync2_q     <= sync1_q;
         prev_q      <= sync2_q;
         cnt_q       <= cnt_d;
         reload_q    <= reload_d;
         cap_q       <= cap_d;
         armed_q     <= armed_d;
         ovf_q       <= ovf_d;
         cap_valid_q <= cap_valid_d;
      end
   end

   // All outputs come straight from registers.
   assign bus.cnt_out   = cnt_q;
   assign bus.cap_out   = cap_q;
   assign bus.ovf       = ovf_q;
   assign bus.cap_valid = cap_valid_q;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array with three 16-bit channels.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, so each step shows the registers updated by the preceding edge.
module tb_timer_array;

   localparam int CH    = 3;
   localparam int CNT_W = 16;
   localparam int PRE_W = 8;
   localparam int CH_W  = 2;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   timer_array_if #(.CH(CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .CH_W(CH_W)) bus ();

   timer_array #(.CH(CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .CH_W(CH_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance n rising edges, then settle 1 ns
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] cnt_of(input int ch);
      return bus.cnt_out[ch*CNT_W +: CNT_W];
   endfunction

   function automatic logic [CNT_W-1:0] cap_of(input int ch);
      return bus.cap_out[ch*CNT_W +: CNT_W];
   endfunction

   initial begin
      // ---------------- reset, pins held high throughout ----------------
      rst              = 1'b1;
      bus.prescale_div = 8'd3;
      bus.ext_in       = '1;
      bus.run          = '0;
      bus.mode         = '0;
      bus.src_ext      = '0;
      bus.wr_en        = 1'b0;
      bus.wr_ch        = '0;
      bus.wr_reload    = 1'b0;
      bus.wr_data      = '0;
      bus.flag_clr     = '0;
      step(2);
      check("rst_cnt_out",   bus.cnt_out,   48'h0);
      check("rst_cap_out",   bus.cap_out,   48'h0);
      check("rst_ovf",       bus.ovf,       3'b000);
      check("rst_cap_valid", bus.cap_valid, 3'b000);

      // ---------------- prescaler: div=3, tick every 4 cycles ----------------
      rst         = 1'b0;
      bus.run     = 3'b001;
      bus.wr_en   = 1'b1;
      bus.wr_ch   = 2'd0;
      bus.wr_data = 16'h0000;
      step(1);
      bus.wr_en   = 1'b0;
      step(2);
      check("pre_cnt_before_tick", cnt_of(0), 16'd0);
      step(1);
      check("pre_cnt_first_tick", cnt_of(0), 16'd1);
      step(36);
      check("pre_cnt_after_40", cnt_of(0), 16'd10);

      // ---------------- free-run wrap, div=0 ----------------
      bus.prescale_div = 8'd0;
      bus.run          = 3'b000;
      bus.wr_en        = 1'b1;
      bus.wr_data      = 16'hFFFE;
      step(1);
      bus.wr_en = 1'b0;
      bus.run   = 3'b001;
      step(1);
      check("free_ffff", cnt_of(0), 16'hFFFF);
      check("free_no_ovf_yet", bus.ovf[0], 1'b0);
      step(1);
      check("free_wrap_cnt", cnt_of(0), 16'h0000);
      check("free_wrap_ovf", bus.ovf[0], 1'b1);
      bus.run      = 3'b000;
      bus.flag_clr = 3'b001;
      step(1);
      check("free_ovf_cleared", bus.ovf[0], 1'b0);
      bus.flag_clr = 3'b000;
      bus.wr_en    = 1'b1;
      bus.wr_data  = 16'hFFFF;
      step(1);
      bus.wr_en    = 1'b0;
      bus.run      = 3'b001;
      bus.flag_clr = 3'b001;
      step(1);
      check("free_wrap2_cnt", cnt_of(0), 16'h0000);
      check("free_set_beats_clr", bus.ovf[0], 1'b1);
      bus.flag_clr = 3'b000;
      bus.run      = 3'b000;

      // ---------------- auto-reload: reload=FFF0, period 16 ticks ----------------
      bus.mode      = 6'b00_00_01;
      bus.wr_en     = 1'b1;
      bus.wr_reload = 1'b1;
      bus.wr_data   = 16'hFFF0;
      bus.flag_clr  = 3'b001;
      step(1);
      bus.wr_reload = 1'b0;
      bus.wr_data   = 16'hFFFF;
      bus.flag_clr  = 3'b000;
      step(1);
      check("rld_start_cnt", cnt_of(0), 16'hFFFF);
      check("rld_start_ovf", bus.ovf[0], 1'b0);
      bus.wr_en = 1'b0;
      bus.run   = 3'b001;
      step(1);
      check("rld_reload_cnt", cnt_of(0), 16'hFFF0);
      check("rld_reload_ovf", bus.ovf[0], 1'b1);
      bus.flag_clr = 3'b001;
      step(1);
      check("rld_ovf_cleared", bus.ovf[0], 1'b0);
      bus.flag_clr = 3'b000;
      step(14);
      check("rld_period_max", cnt_of(0), 16'hFFFF);
      check("rld_period_no_ovf", bus.ovf[0], 1'b0);
      step(1);
      check("rld_period_reload", cnt_of(0), 16'hFFF0);
      check("rld_period_ovf", bus.ovf[0], 1'b1);
      bus.run = 3'b000;

      // ---------------- one-shot ----------------
      bus.mode     = 6'b00_00_10;
      bus.wr_en    = 1'b1;
      bus.wr_data  = 16'hFFFD;
      bus.flag_clr = 3'b001;
      step(1);
      bus.wr_en    = 1'b0;
      bus.flag_clr = 3'b000;
      bus.run      = 3'b001;
      step(2);
      check("os_ffff", cnt_of(0), 16'hFFFF);
      step(1);
      check("os_expire_cnt", cnt_of(0), 16'h0000);
      check("os_expire_ovf", bus.ovf[0], 1'b1);
      step(5);
      check("os_held_zero", cnt_of(0), 16'h0000);
      // rewrite while ticking: write wins over the event and re-arms
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'h0005;
      step(1);
      check("wr_beats_event", cnt_of(0), 16'h0005);
      bus.wr_en = 1'b0;
      step(1);
      check("os_rearmed", cnt_of(0), 16'h0006);
      bus.run = 3'b000;

      // ---------------- ch1 external falling-edge count ----------------
      bus.run     = 3'b010;
      bus.src_ext = 3'b010;
      for (int p = 1; p <= 5; p++) begin
         bus.ext_in[1] = 1'b0;
         step(2);
         check($sformatf("ext_pulse%0d_lag", p), cnt_of(1), 16'(p - 1));
         step(1);
         check($sformatf("ext_pulse%0d_cnt", p), cnt_of(1), 16'(p));
         step(1);
         bus.ext_in[1] = 1'b1;
         step(4);
      end
      check("ext_final", cnt_of(1), 16'd5);

      // ---------------- ch2 capture (src_ext set but ignored for counting) ----------------
      bus.run     = 3'b100;
      bus.src_ext = 3'b110;
      bus.mode    = 6'b11_00_10;
      bus.wr_en   = 1'b1;
      bus.wr_ch   = 2'd2;
      bus.wr_data = 16'h0120;
      step(1);
      bus.wr_en = 1'b0;
      step(1);
      bus.ext_in[2] = 1'b0;
      step(2);
      check("cap_cnt_before", cnt_of(2), 16'h0123);
      check("cap_valid_before", bus.cap_valid[2], 1'b0);
      step(1);
      check("cap_value", cap_of(2), 16'h0123);
      check("cap_valid_set", bus.cap_valid[2], 1'b1);
      check("cap_cnt_after", cnt_of(2), 16'h0124);
      bus.run       = 3'b000;
      bus.flag_clr  = 3'b100;
      bus.ext_in[2] = 1'b1;
      step(1);
      check("cap_valid_cleared", bus.cap_valid[2], 1'b0);
      check("cap_value_held", cap_of(2), 16'h0123);
      bus.flag_clr = 3'b000;

      // ---------------- out-of-range channel write ----------------
      bus.wr_en   = 1'b1;
      bus.wr_ch   = 2'd3;
      bus.wr_data = 16'hBEEF;
      step(1);
      bus.wr_en = 1'b0;
      check("wr_ch_out_of_range", bus.cnt_out, {16'h0124, 16'h0005, 16'h0006});

      // ---------------- reset while counting ----------------
      bus.run = 3'b111;
      step(3);
      rst = 1'b1;
      step(1);
      check("midrst_cnt_out",   bus.cnt_out,   48'h0);
      check("midrst_cap_out",   bus.cap_out,   48'h0);
      check("midrst_ovf",       bus.ovf,       3'b000);
      check("midrst_cap_valid", bus.cap_valid, 3'b000);
      rst     = 1'b0;
      bus.run = 3'b000;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
